// File: rtl/gate_vec_pkg.sv
// Shared types and the m7458 dual AND-OR reference function for the vector sequencer.
package gate_vec_pkg;

   localparam int VEC_W = 10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DRIVE,
      SAMPLE,
      DONE
   } state_t;

   // Pin order: {a,b,c,d,e,f,g,h,i,j} = v[9:0]; returns {p1y,p2y}
   function automatic logic [1:0] m7458_model(input logic [VEC_W-1:0] v);
      logic p1y;
      logic p2y;
      p1y = (v[9] & v[8] & v[7]) | (v[6] & v[5] & v[4]);
      p2y = (v[3] & v[2]) | (v[1] & v[0]);
      return {p1y, p2y};
   endfunction

endpackage

// File: rtl/gate_vec_ram.sv
// Vector table: sync write, registered read-enable output that doubles as the inp driver.
// Read data lands one cycle after rd_en; the output register is reset and otherwise holds.
module gate_vec_ram
   import gate_vec_pkg::*;
#(
   parameter int NUM_VEC = 16,
   parameter int AW      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [VEC_W-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [VEC_W-1:0] rd_data
);

   // Depth rounded up to the address space so every address decodes cleanly
   localparam int DEPTH = 2 ** AW;

   logic [VEC_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/gate_vec_seq.sv
// Replays the vector table into the m7458, samples {p1y,p2y} after HOLD_CYC cycles and scores it.
// Each vector takes HOLD_CYC+2 cycles; start and table writes are ignored while busy.
module gate_vec_seq
   import gate_vec_pkg::*;
#(
   parameter  int NUM_VEC  = 16,
   parameter  int HOLD_CYC = 10,
   localparam int AW       = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [VEC_W-1:0] wr_data,
   input  logic             start,
   input  logic [1:0]       dut_y,
   output logic [VEC_W-1:0] inp,
   output logic             busy,
   output logic             done,
   output logic [7:0]       err_cnt,
   output logic [AW-1:0]    first_err,
   output logic [8:0]       trig_cnt
);

   localparam int            CW       = $clog2(HOLD_CYC);
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_VEC - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYC - 1);

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] idx;
   logic [CW-1:0] hold_cnt;
   logic          idle_like;
   logic          run_go;
   logic          wr_go;
   logic [1:0]    exp_y;
   logic          mism;

   assign idle_like = (state == IDLE) || (state == DONE);
   assign run_go    = start && idle_like;
   assign wr_go     = wr_en && idle_like;
   assign busy      = !idle_like;
   assign done      = (state == DONE);
   assign exp_y     = m7458_model(inp);
   assign mism      = (dut_y != exp_y);

   // The RAM read register is the inp driver, so inp updates on the edge that ends LOAD
   gate_vec_ram #(
      .NUM_VEC (NUM_VEC),
      .AW      (AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_go),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (state == LOAD),
      .rd_addr (idx),
      .rd_data (inp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (run_go) state_nxt = LOAD;
         LOAD:       state_nxt = DRIVE;
         DRIVE:      if (hold_cnt == LAST_CNT) state_nxt = SAMPLE;
         SAMPLE:     state_nxt = (idx == LAST_IDX) ? DONE : LOAD;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         hold_cnt  <= '0;
         err_cnt   <= '0;
         first_err <= '0;
         trig_cnt  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (run_go) begin
                  idx       <= '0;
                  err_cnt   <= '0;
                  first_err <= '0;
                  trig_cnt  <= '0;
               end
            end
            LOAD: hold_cnt <= '0;
            DRIVE: begin
               if (hold_cnt != LAST_CNT) hold_cnt <= hold_cnt + 1'b1;
            end
            SAMPLE: begin
               if (mism) begin
                  if (err_cnt == 8'd0) first_err <= idx;
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
               end
               if (exp_y != 2'b00) trig_cnt <= trig_cnt + 1'b1;
               if (idx != LAST_IDX) idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_vec_seq.sv
// Directed/randomized bench for gate_vec_seq: three instances cover the default, 256-entry and 1-entry shapes.
module tb_gate_vec_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Instance A: NUM_VEC=16, HOLD_CYC=10
   logic       start_a, wr_en_a;
   logic [3:0] wr_addr_a;
   logic [9:0] wr_data_a, inp_a;
   logic [1:0] dut_y_a;
   logic       busy_a, done_a;
   logic [7:0] err_a;
   logic [3:0] first_a;
   logic [8:0] trig_a;
   int         mode_a = 0;

   // Instance B: NUM_VEC=256, HOLD_CYC=2
   logic       start_b, wr_en_b;
   logic [7:0] wr_addr_b;
   logic [9:0] wr_data_b, inp_b;
   logic [1:0] dut_y_b;
   logic       busy_b, done_b;
   logic [7:0] err_b;
   logic [7:0] first_b;
   logic [8:0] trig_b;
   int         mode_b = 0;

   // Instance C: NUM_VEC=1, HOLD_CYC=2
   logic       start_c, wr_en_c;
   logic [0:0] wr_addr_c;
   logic [9:0] wr_data_c, inp_c;
   logic [1:0] dut_y_c;
   logic       busy_c, done_c;
   logic [7:0] err_c;
   logic [0:0] first_c;
   logic [8:0] trig_c;

   logic [9:0] tbl_a[$];
   logic [9:0] tbl_b[$];

   // Reference m7458 written as group comparisons
   function automatic logic [1:0] gold(input logic [9:0] v);
      logic [1:0] r;
      r[1] = (v[9:7] == 3'b111) || (v[6:4] == 3'b111);
      r[0] = (v[3:2] == 2'b11) || (v[1:0] == 2'b11);
      return r;
   endfunction

   // 0: healthy gate, 1: p2y stuck at 0, 2: both outputs inverted
   function automatic logic [1:0] fault(input logic [1:0] g, input int mode);
      if (mode == 1) return {g[1], 1'b0};
      if (mode == 2) return ~g;
      return g;
   endfunction

   assign dut_y_a = fault(gold(inp_a), mode_a);
   assign dut_y_b = fault(gold(inp_b), mode_b);
   assign dut_y_c = gold(inp_c);

   gate_vec_seq #(.NUM_VEC(16), .HOLD_CYC(10)) u_a (
      .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
      .start(start_a), .dut_y(dut_y_a), .inp(inp_a), .busy(busy_a), .done(done_a),
      .err_cnt(err_a), .first_err(first_a), .trig_cnt(trig_a));

   gate_vec_seq #(.NUM_VEC(256), .HOLD_CYC(2)) u_b (
      .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
      .start(start_b), .dut_y(dut_y_b), .inp(inp_b), .busy(busy_b), .done(done_b),
      .err_cnt(err_b), .first_err(first_b), .trig_cnt(trig_b));

   gate_vec_seq #(.NUM_VEC(1), .HOLD_CYC(2)) u_c (
      .clk(clk), .rst(rst), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
      .start(start_c), .dut_y(dut_y_c), .inp(inp_c), .busy(busy_c), .done(done_c),
      .err_cnt(err_c), .first_err(first_c), .trig_cnt(trig_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Expected scores for a whole run over table t under fault mode
   task automatic model(input logic [9:0] t[$], input int mode,
                        output int e_err, output int e_first, output int e_trig);
      int mis;
      logic [1:0] g;
      mis = 0; e_first = 0; e_trig = 0;
      foreach (t[i]) begin
         g = gold(t[i]);
         if (fault(g, mode) != g) begin
            if (mis == 0) e_first = i;
            mis++;
         end
         if (g != 2'b00) e_trig++;
      end
      e_err = (mis > 255) ? 255 : mis;
   endtask

   task automatic wr_a(input int addr, input logic [9:0] data);
      wr_en_a = 1'b1; wr_addr_a = 4'(addr); wr_data_a = data;
      tick();
      wr_en_a = 1'b0;
      tbl_a[addr] = data;
   endtask

   // One run on A; optional write coincident with start, optional start/write poke while busy
   task automatic run_a(input string tag, input int mode, input bit do_wr, input bit do_poke);
      int cyc, e_err, e_first, e_trig;
      mode_a = mode;
      start_a = 1'b1;
      if (do_wr) begin
         wr_en_a = 1'b1; wr_addr_a = 4'd0; wr_data_a = 10'h3FF;
         tbl_a[0] = 10'h3FF;
      end
      tick();
      start_a = 1'b0; wr_en_a = 1'b0;
      chk({tag, " busy"}, 32'(busy_a), 1);
      chk({tag, " cleared"}, 32'({done_a, err_a, trig_a}), 0);
      tick();
      chk({tag, " vec0"}, 32'(inp_a), 32'(tbl_a[0]));
      cyc = 1;
      while (!done_a && cyc < 1000) begin
         if (do_poke && cyc == 40) begin
            start_a = 1'b1; wr_en_a = 1'b1; wr_addr_a = 4'd15; wr_data_a = ~tbl_a[15];
         end else begin
            start_a = 1'b0; wr_en_a = 1'b0;
         end
         tick();
         cyc++;
      end
      start_a = 1'b0; wr_en_a = 1'b0;
      model(tbl_a, mode, e_err, e_first, e_trig);
      chk({tag, " cycles"}, 32'(cyc), 192);
      chk({tag, " busy_end"}, 32'(busy_a), 0);
      chk({tag, " err_cnt"}, 32'(err_a), 32'(e_err));
      chk({tag, " first_err"}, 32'(first_a), 32'(e_first));
      chk({tag, " trig_cnt"}, 32'(trig_a), 32'(e_trig));
      chk({tag, " inp_last"}, 32'(inp_a), 32'(tbl_a[15]));
   endtask

   task automatic wait_b(input string tag);
      int cyc, e_err, e_first, e_trig;
      cyc = 0;
      while (!done_b && cyc < 3000) begin
         tick();
         cyc++;
      end
      model(tbl_b, mode_b, e_err, e_first, e_trig);
      chk({tag, " cycles"}, 32'(cyc), 1024);
      chk({tag, " err_cnt"}, 32'(err_b), 32'(e_err));
      chk({tag, " first_err"}, 32'(first_b), 32'(e_first));
      chk({tag, " trig_cnt"}, 32'(trig_b), 32'(e_trig));
   endtask

   initial begin
      int cyc, hi;
      rst = 1'b1;
      start_a = 0; wr_en_a = 0; wr_addr_a = 0; wr_data_a = 0;
      start_b = 0; wr_en_b = 0; wr_addr_b = 0; wr_data_b = 0;
      start_c = 0; wr_en_c = 0; wr_addr_c = 0; wr_data_c = 0;
      tick(); tick();
      chk("reset inp", 32'(inp_a), 0);
      chk("reset flags", 32'({busy_a, done_a}), 0);
      chk("reset counters", 32'({err_a, first_a, trig_a}), 0);
      rst = 1'b0;
      tick();

      tbl_a = '{10'h000, 10'h001, 10'h002, 10'h012, 10'h017, 10'h025, 10'h023, 10'h3FF,
                10'h012, 10'h256, 10'h021, 10'h045, 10'h253, 10'h093, 10'h048, 10'h000};
      for (int i = 0; i < 16; i++) wr_a(i, tbl_a[i]);

      run_a("t1 golden", 0, 1'b0, 1'b0);
      run_a("t2 p2y_stuck", 1, 1'b0, 1'b0);

      // Reset in the middle of vector 5's hold window
      start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (64) tick();
      chk("t3 on vec5", 32'(inp_a), 32'(tbl_a[5]));
      rst = 1'b1;
      #1;
      chk("t3 rst inp", 32'(inp_a), 0);
      chk("t3 rst flags", 32'({busy_a, done_a}), 0);
      chk("t3 rst counters", 32'({err_a, first_a, trig_a}), 0);
      tick();
      rst = 1'b0;
      tick();
      run_a("t3 rerun+wr", 0, 1'b1, 1'b0);

      run_a("t4 poke", 1, 1'b0, 1'b1);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 16; i++) wr_a(i, 10'($urandom_range(0, 1023)));
         run_a($sformatf("rand%0d", r), int'($urandom_range(0, 2)), 1'b0, 1'b0);
      end

      // 256-entry table, every vector mismatching: saturate, restart, saturate again
      for (int i = 0; i < 256; i++) begin
         tbl_b.push_back(10'($urandom_range(0, 1023)));
         wr_en_b = 1'b1; wr_addr_b = 8'(i); wr_data_b = tbl_b[i];
         tick();
      end
      wr_en_b = 1'b0;
      mode_b = 2;
      start_b = 1'b1; tick(); start_b = 1'b0;
      wait_b("t5 run1");
      start_b = 1'b1; tick(); start_b = 1'b0;
      chk("t5 restart clear", 32'({done_b, err_b, first_b, trig_b}), 0);
      chk("t5 restart busy", 32'(busy_b), 1);
      wait_b("t5 run2");

      // Single-vector instance
      wr_en_c = 1'b1; wr_addr_c = 1'b0; wr_data_c = 10'h3FF;
      tick();
      wr_en_c = 1'b0;
      start_c = 1'b1; tick(); start_c = 1'b0;
      chk("t6 load inp", 32'(inp_c), 0);
      cyc = 0; hi = 0;
      while (!done_c && cyc < 100) begin
         tick();
         cyc++;
         if (inp_c == 10'h3FF) hi++;
      end
      chk("t6 cycles", 32'(cyc), 4);
      chk("t6 inp_held", 32'(hi), 4);
      chk("t6 trig_cnt", 32'(trig_c), 1);
      chk("t6 err_cnt", 32'(err_c), 0);
      chk("t6 busy", 32'(busy_c), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
